// File: rtl/pixel_tap_buffer.sv
// Multi-tap pixel delay line: one block RAM per tap, all written in lockstep,
// with a zeroing sweep after reset or on request and per-tap valid flags.
module pixel_tap_buffer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned NUM_TAPS    = 8,
    parameter int unsigned FIRST_TAP   = 1,
    parameter int unsigned TAP_SPACING = 128
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      shift_en,
    input  logic [WIDTH-1:0]          shiftin,
    output logic [NUM_TAPS*WIDTH-1:0] taps,
    output logic [NUM_TAPS-1:0]       tap_valid,
    output logic [WIDTH-1:0]          shiftout,
    output logic                      busy
);

    localparam int unsigned           DEPTH      = 1 << ADDR_WIDTH;
    localparam int unsigned           LAST_DELAY = FIRST_TAP + (NUM_TAPS - 1) * TAP_SPACING;
    localparam logic [ADDR_WIDTH:0]   FILL_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};

    // The longest delay must stay below DEPTH so a tap never reads the address being written.
    if (NUM_TAPS < 1 || FIRST_TAP < 1 || TAP_SPACING < 1 || LAST_DELAY > DEPTH - 1) begin : g_param_check
        $error("pixel_tap_buffer: tap delays do not fit in the per-tap memory depth");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [ADDR_WIDTH-1:0] sweep_addr_r;
    logic [ADDR_WIDTH-1:0] wrptr_r;
    logic [ADDR_WIDTH:0]   fill_r;
    logic                  busy_r;
    logic                  shift_s;
    logic                  restart_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [WIDTH-1:0]      mem_data_s;

    // Next-state decode and shared write-port steering for all tap memories.
    always_comb begin
        next_state_s = state_r;
        shift_s      = 1'b0;
        restart_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = wrptr_r;
        mem_data_s   = shiftin;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s   = 1'b1;
                mem_addr_s = sweep_addr_r;
                mem_data_s = '0;
                if (sweep_addr_r == ADDR_LAST) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    restart_s    = 1'b1;
                    next_state_s = ST_CLEAR;
                end else begin
                    shift_s  = shift_en;
                    mem_we_s = shift_en;
                end
            end
            default: begin
                next_state_s = ST_CLEAR;
            end
        endcase
    end

    // State, sweep address, write pointer, fill level and busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_CLEAR;
            sweep_addr_r <= '0;
            wrptr_r      <= '0;
            fill_r       <= '0;
            busy_r       <= 1'b1;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_CLEAR);
            if (state_r == ST_CLEAR) begin
                sweep_addr_r <= sweep_addr_r + 1'b1;
            end else begin
                sweep_addr_r <= '0;
            end
            if (restart_s) begin
                wrptr_r <= '0;
                fill_r  <= '0;
            end else if (shift_s) begin
                wrptr_r <= wrptr_r + 1'b1;
                if (fill_r != FILL_FULL) begin
                    fill_r <= fill_r + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        localparam int unsigned           DELAY      = FIRST_TAP + k * TAP_SPACING;
        localparam logic [ADDR_WIDTH-1:0] DELAY_ADDR = ADDR_WIDTH'(DELAY);
        localparam logic [ADDR_WIDTH:0]   DELAY_FILL = (ADDR_WIDTH + 1)'(DELAY);

        logic [WIDTH-1:0]      mem_r [DEPTH];
        logic [WIDTH-1:0]      tap_r;
        logic                  valid_r;
        logic [ADDR_WIDTH-1:0] rd_addr_s;

        assign rd_addr_s = wrptr_r - DELAY_ADDR;

        // Block RAM write port, shared address and data across taps.
        always_ff @(posedge clock) begin
            if (mem_we_s) begin
                mem_r[mem_addr_s] <= mem_data_s;
            end
        end

        // Synchronous read into the tap register; valid latches once fill reaches the delay.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                tap_r   <= '0;
                valid_r <= 1'b0;
            end else if (restart_s) begin
                tap_r   <= '0;
                valid_r <= 1'b0;
            end else if (shift_s) begin
                tap_r   <= mem_r[rd_addr_s];
                valid_r <= (fill_r >= DELAY_FILL);
            end
        end

        assign taps[k*WIDTH +: WIDTH] = tap_r;
        assign tap_valid[k]           = valid_r;
    end

    assign shiftout = taps[(NUM_TAPS-1)*WIDTH +: WIDTH];
    assign busy     = busy_r;

endmodule

// File: tb/tb_pixel_tap_buffer.sv
// Self-checking bench for pixel_tap_buffer: default geometry plus a small one,
// both compared against a sample-history model of the delay line.
module tb_pixel_tap_buffer;

    localparam int W      = 32;
    localparam int A_TAPS = 8;
    localparam int B_TAPS = 3;

    typedef struct {
        int          n;
        int          tap;
        logic [31:0] exp_tap;
        logic [7:0]  exp_valid;
        logic [31:0] exp_shiftout;
    } vec_t;

    logic clock;

    logic                reset_a, clear_a, shift_en_a, busy_a;
    logic [W-1:0]        shiftin_a, shiftout_a;
    logic [A_TAPS*W-1:0] taps_a;
    logic [A_TAPS-1:0]   valid_a;

    logic                reset_b, clear_b, shift_en_b, busy_b;
    logic [W-1:0]        shiftin_b, shiftout_b;
    logic [B_TAPS*W-1:0] taps_b;
    logic [B_TAPS-1:0]   valid_b;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] hist_a [0:8191];
    logic [W-1:0] hist_b [0:1023];
    int           n_a = 0;
    int           n_b = 0;
    vec_t         tbl [6];

    pixel_tap_buffer dut_a (
        .clock    (clock),
        .reset    (reset_a),
        .clear    (clear_a),
        .shift_en (shift_en_a),
        .shiftin  (shiftin_a),
        .taps     (taps_a),
        .tap_valid(valid_a),
        .shiftout (shiftout_a),
        .busy     (busy_a)
    );

    pixel_tap_buffer #(
        .WIDTH      (32),
        .ADDR_WIDTH (4),
        .NUM_TAPS   (3),
        .FIRST_TAP  (2),
        .TAP_SPACING(5)
    ) dut_b (
        .clock    (clock),
        .reset    (reset_b),
        .clear    (clear_b),
        .shift_en (shift_en_b),
        .shiftin  (shiftin_b),
        .taps     (taps_b),
        .tap_valid(valid_b),
        .shiftout (shiftout_b),
        .busy     (busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int delay_a(input int k);
        return 1 + k * 128;
    endfunction

    function automatic int delay_b(input int k);
        return 2 + k * 5;
    endfunction

    task automatic compare(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Tap k shows the sample accepted D_k shifts before the latest one, else zero.
    task automatic check_a(input string name, input logic exp_busy);
        logic [A_TAPS*W-1:0] et;
        logic [A_TAPS-1:0]   ev;
        et = '0;
        ev = '0;
        for (int k = 0; k < A_TAPS; k++) begin
            if (n_a > delay_a(k)) begin
                et[k*W +: W] = hist_a[n_a-1-delay_a(k)];
                ev[k]        = 1'b1;
            end
        end
        compare({name, ".taps"},     256'(taps_a),     256'(et));
        compare({name, ".valid"},    256'(valid_a),    256'(ev));
        compare({name, ".shiftout"}, 256'(shiftout_a), 256'(et[(A_TAPS-1)*W +: W]));
        compare({name, ".busy"},     256'(busy_a),     256'(exp_busy));
    endtask

    task automatic check_b(input string name, input logic exp_busy);
        logic [B_TAPS*W-1:0] et;
        logic [B_TAPS-1:0]   ev;
        et = '0;
        ev = '0;
        for (int k = 0; k < B_TAPS; k++) begin
            if (n_b > delay_b(k)) begin
                et[k*W +: W] = hist_b[n_b-1-delay_b(k)];
                ev[k]        = 1'b1;
            end
        end
        compare({name, ".taps"},     256'(taps_b),     256'(et));
        compare({name, ".valid"},    256'(valid_b),    256'(ev));
        compare({name, ".shiftout"}, 256'(shiftout_b), 256'(et[(B_TAPS-1)*W +: W]));
        compare({name, ".busy"},     256'(busy_b),     256'(exp_busy));
    endtask

    task automatic shift_a(input logic [W-1:0] v, input logic en, input string name);
        clear_a    = 1'b0;
        shift_en_a = en;
        shiftin_a  = v;
        @(posedge clock); #1;
        shift_en_a = 1'b0;
        if (en) begin
            hist_a[n_a] = v;
            n_a++;
        end
        check_a(name, 1'b0);
    endtask

    task automatic shift_b(input logic [W-1:0] v, input logic en, input string name);
        clear_b    = 1'b0;
        shift_en_b = en;
        shiftin_b  = v;
        @(posedge clock); #1;
        shift_en_b = 1'b0;
        if (en) begin
            hist_b[n_b] = v;
            n_b++;
        end
        check_b(name, 1'b0);
    endtask

    // Count busy cycles while throwing random traffic at the ignored inputs.
    task automatic wait_sweep(input int which, input int exp_len, input string name);
        int cnt   = 0;
        bit dirty = 1'b0;
        while ((((which == 0) ? busy_a : busy_b) === 1'b1) && cnt < 3000) begin
            if (which == 0) begin
                if (taps_a !== '0 || valid_a !== '0 || shiftout_a !== '0) dirty = 1'b1;
                clear_a    = ($urandom_range(0, 7) == 0);
                shift_en_a = 1'($urandom_range(0, 1));
                shiftin_a  = $urandom;
            end else begin
                if (taps_b !== '0 || valid_b !== '0 || shiftout_b !== '0) dirty = 1'b1;
                clear_b    = ($urandom_range(0, 7) == 0);
                shift_en_b = 1'($urandom_range(0, 1));
                shiftin_b  = $urandom;
            end
            cnt++;
            @(posedge clock); #1;
        end
        clear_a    = 1'b0;
        shift_en_a = 1'b0;
        clear_b    = 1'b0;
        shift_en_b = 1'b0;
        compare({name, ".busy_len"},     256'(cnt),   256'(exp_len));
        compare({name, ".zero_outputs"}, 256'(dirty), 256'(0));
    endtask

    // Ramp 1,2,3,... from an empty buffer and hit the table checkpoints.
    task automatic apply_table(input string tag);
        for (int i = 0; i < 6; i++) begin
            while (n_a < tbl[i].n) shift_a(32'(n_a + 1), 1'b1, {tag, ".ramp"});
            compare($sformatf("%s.tbl%0d.tap%0d", tag, i, tbl[i].tap),
                    256'(taps_a[tbl[i].tap*W +: W]), 256'(tbl[i].exp_tap));
            compare($sformatf("%s.tbl%0d.valid", tag, i), 256'(valid_a), 256'(tbl[i].exp_valid));
            compare($sformatf("%s.tbl%0d.shiftout", tag, i), 256'(shiftout_a), 256'(tbl[i].exp_shiftout));
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int guard;
        tbl[0] = '{n: 1,   tap: 0, exp_tap: 32'd0, exp_valid: 8'h00, exp_shiftout: 32'd0};
        tbl[1] = '{n: 2,   tap: 0, exp_tap: 32'd1, exp_valid: 8'h01, exp_shiftout: 32'd0};
        tbl[2] = '{n: 130, tap: 1, exp_tap: 32'd1, exp_valid: 8'h03, exp_shiftout: 32'd0};
        tbl[3] = '{n: 770, tap: 6, exp_tap: 32'd1, exp_valid: 8'h7F, exp_shiftout: 32'd0};
        tbl[4] = '{n: 897, tap: 7, exp_tap: 32'd0, exp_valid: 8'h7F, exp_shiftout: 32'd0};
        tbl[5] = '{n: 898, tap: 7, exp_tap: 32'd1, exp_valid: 8'hFF, exp_shiftout: 32'd1};

        reset_a = 1'b1; clear_a = 1'b0; shift_en_a = 1'b0; shiftin_a = '0;
        reset_b = 1'b1; clear_b = 1'b0; shift_en_b = 1'b0; shiftin_b = '0;
        repeat (3) @(posedge clock);
        #1;
        check_a("a_reset", 1'b1);
        check_b("b_reset", 1'b1);

        // Sweep after reset release, then the fill ramp.
        reset_a = 1'b0;
        wait_sweep(0, 1024, "a_sweep_reset");
        n_a = 0;
        check_a("a_idle_after_sweep", 1'b0);
        apply_table("a_fill");
        while (n_a < 900) shift_a(32'(n_a + 1), 1'b1, "a_ramp");

        // Random idle gaps and multiple pointer wraps.
        guard = 0;
        while (n_a < 5000 && guard < 400) begin
            guard++;
            repeat ($urandom_range(0, 6)) shift_a($urandom, 1'b0, "a_gap_hold");
            repeat ($urandom_range(10, 40)) if (n_a < 5000) shift_a($urandom, 1'b1, "a_stream");
        end
        compare("a_stream_count", 256'(n_a), 256'(5000));

        // Plain clear, then a clear that collides with a shift at sample 300.
        clear_a = 1'b1;
        @(posedge clock); #1;
        clear_a = 1'b0;
        n_a = 0;
        check_a("a_after_clear", 1'b1);
        wait_sweep(0, 1024, "a_sweep_clear");
        while (n_a < 299) shift_a(32'h0001_0000 + 32'(n_a), 1'b1, "a_preclash");
        clear_a    = 1'b1;
        shift_en_a = 1'b1;
        shiftin_a  = 32'hC1A5_C1A5;
        @(posedge clock); #1;
        clear_a    = 1'b0;
        shift_en_a = 1'b0;
        n_a = 0;
        check_a("a_clash_clear", 1'b1);
        wait_sweep(0, 1024, "a_sweep_clash");
        apply_table("a_refill");
        while (n_a < 900) shift_a(32'(n_a + 1), 1'b1, "a_refill_ramp");

        // Small geometry: delays 2/7/12 on a 16-deep memory.
        reset_b = 1'b0;
        wait_sweep(1, 16, "b_sweep_reset");
        n_b = 0;
        for (int i = 0; i < 12; i++) shift_b($urandom, 1'b1, "b_fill");
        compare("b_valid_after_12", 256'(valid_b), 256'(3'b011));
        shift_b($urandom, 1'b1, "b_fill13");
        compare("b_valid_after_13", 256'(valid_b), 256'(3'b111));
        compare("b_tap2_after_13",  256'(taps_b[2*W +: W]), 256'(hist_b[0]));
        for (int i = 0; i < 200 && n_b < 20; i++) shift_b($urandom, 1'($urandom_range(0, 1)), "b_mixed");
        compare("b_count_before_reset", 256'(n_b), 256'(20));

        // Asynchronous reset mid-stream clears outputs before any edge.
        reset_b = 1'b1;
        #1;
        n_b = 0;
        check_b("b_async_reset", 1'b1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_b = 1'b0;
        wait_sweep(1, 16, "b_sweep_after_reset");
        for (int i = 0; i < 40; i++) shift_b($urandom, 1'($urandom_range(0, 3) != 0), "b_refill");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
